// File: rtl/regfile_2r1w_pkg.sv
// Shared widths and zero-register policy so decode, writeback and the
// register file agree on operand and address sizes.
package regfile_2r1w_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam bit ZERO_REG_DEF = 1'b1;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: write-first bypass, hardwired-zero override,
// then a data register that only loads on a request and a one-cycle valid.
module regfile_read_port
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = ZERO_REG_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  logic [DATA_W-1:0] nextData;

  // Zero override is applied last so a bypassed write to entry 0 never leaks.
  always_comb begin
    nextData = rdata;
    if (we && (waddr == addr)) begin
      nextData = wdata;
    end
    if (ZERO_REG && (addr == '0)) begin
      nextData = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= req;
      if (req) begin
        data <= nextData;
      end
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with one write port and two independent registered read
// ports feeding ALU operands A and B.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = ZERO_REG_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ra_req,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic              rb_req,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic              ra_valid,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              writeOk;

  assign writeOk = we && !(ZERO_REG && (waddr == '0));

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeOk) begin
      regs[waddr] <= wdata;
    end
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) portA (
    .clk  (clk),
    .clr  (clr),
    .req  (ra_req),
    .addr (ra_addr),
    .rdata(regs[ra_addr]),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .data (ra_data),
    .valid(ra_valid)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) portB (
    .clk  (clk),
    .clr  (clr),
    .req  (rb_req),
    .addr (rb_addr),
    .rdata(regs[rb_addr]),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .data (rb_data),
    .valid(rb_valid)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: expected read data is queued when a
// request is driven and popped when the matching valid pulse appears.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        clr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        ra_req;
  logic [4:0]  ra_addr;
  logic        rb_req;
  logic [4:0]  rb_addr;
  logic [31:0] ra_data;
  logic        ra_valid;
  logic [31:0] rb_data;
  logic        rb_valid;

  logic [31:0] mem [32];
  logic [31:0] qA [$];
  logic [31:0] qB [$];
  logic [31:0] heldA;
  logic [31:0] heldB;
  int          checks = 0;
  int          errors = 0;

  regfile_2r1w dut (
    .clk     (clk),
    .clr     (clr),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .ra_req  (ra_req),
    .ra_addr (ra_addr),
    .rb_req  (rb_req),
    .rb_addr (rb_addr),
    .ra_data (ra_data),
    .ra_valid(ra_valid),
    .rb_data (rb_data),
    .rb_valid(rb_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a, input logic w,
                                            input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (w && wa == a) return wd;
    return mem[a];
  endfunction

  // One clock of stimulus; reference model and scoreboard advance with it.
  task automatic applyStimulus(input logic c, input logic w, input logic [4:0] wa,
                               input logic [31:0] wd, input logic ar, input logic [4:0] aa,
                               input logic br, input logic [4:0] ba);
    logic [31:0] exp;
    clr = c; we = w; waddr = wa; wdata = wd;
    ra_req = ar; ra_addr = aa; rb_req = br; rb_addr = ba;
    if (!c && ar) qA.push_back(modelRead(aa, w, wa, wd));
    if (!c && br) qB.push_back(modelRead(ba, w, wa, wd));
    @(posedge clk);
    #1;
    if (c) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      heldA = 32'd0;
      heldB = 32'd0;
    end else if (w && wa != 5'd0) begin
      mem[wa] = wd;
    end
    checkOutput("ra_valid", {31'd0, ra_valid}, {31'd0, !c && ar});
    checkOutput("rb_valid", {31'd0, rb_valid}, {31'd0, !c && br});
    if (ra_valid) begin
      if (qA.size() == 0) checkOutput("ra_queue_empty", 32'd1, 32'd0);
      else begin
        exp = qA.pop_front();
        heldA = exp;
      end
    end
    if (rb_valid) begin
      if (qB.size() == 0) checkOutput("rb_queue_empty", 32'd1, 32'd0);
      else begin
        exp = qB.pop_front();
        heldB = exp;
      end
    end
    checkOutput("ra_data", ra_data, heldA);
    checkOutput("rb_data", rb_data, heldB);
  endtask

  initial begin
    heldA = 32'd0;
    heldB = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++) applyStimulus(0, 1, 5'(i), 32'hA000 + i, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 32'hBAD0BAD0, 1, 5, 1, 6);
    for (int i = 1; i < 32; i++) applyStimulus(0, 0, 0, 0, 1, 5'(i), 1, 5'(32 - i));

    $display("[TB] basic write/read");
    applyStimulus(0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 7, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 'x, 0, 'x);

    $display("[TB] bypass");
    applyStimulus(0, 1, 12, 32'h12345678, 1, 12, 1, 12);
    applyStimulus(0, 0, 0, 0, 1, 12, 1, 12);

    $display("[TB] zero register");
    applyStimulus(0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

    $display("[TB] independent ports");
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 5'(i), 32'h100 + i, 0, 0, 0, 0);
    for (int i = 28; i <= 31; i++) applyStimulus(0, 1, 5'(i), 32'h100 + i, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 5'(i + 1), 1, 5'(31 - i));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++)
      applyStimulus(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));

    $display("[TB] reset mid-stream");
    applyStimulus(0, 1, 5, 32'h55AA55AA, 1, 5, 1, 3);
    applyStimulus(1, 1, 5, 32'h0BADF00D, 1, 5, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 5, 1, 5);

    checkOutput("qA_drained", 32'(qA.size()), 32'd0);
    checkOutput("qB_drained", 32'(qB.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Processor register file: 2^ADDR_W entries of DATA_W bits.
- One write port and two registered read ports with request/valid handshakes.
- This is the read side that pairs with the per-register write storage (d/en/clr style).
- Sits between decode (read addresses) and writeback (write address/data); supplies operands A and B to the ALU stage.

Parameters:
DATA_W, 32, width of each register and of all data ports
ADDR_W, 5, address width; number of entries NREGS = 2**ADDR_W
ZERO_REG, 1, when 1 entry 0 is hardwired to zero (reads 0, writes dropped)

Ports:
clk  input  1  rising-edge clock; all state updates on this edge only
clr  input  1  reset, synchronous, active-high
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
ra_req  input  1  read request, port A
ra_addr  input  ADDR_W  read address, port A
rb_req  input  1  read request, port B
rb_addr  input  ADDR_W  read address, port B
ra_data  output  DATA_W  registered read data, port A
ra_valid  output  1  ra_data updated by request of previous cycle
rb_data  output  DATA_W  registered read data, port B
rb_valid  output  1  rb_data updated by request of previous cycle

Behaviour:
- Reset: clr=1 at an edge clears every entry to 0, ra_data=rb_data=0, ra_valid=rb_valid=0. clr dominates we, ra_req and rb_req in the same cycle; the write and the reads are dropped.
- Write: at an edge with clr=0 and we=1, entry[waddr] <= wdata. If ZERO_REG=1 and waddr=0, the write is discarded.
- Read latency is 1 cycle. Port A (port B identical and fully independent):
  - ra_req=1 at edge N -> after edge N, ra_data = entry[ra_addr] and ra_valid=1.
  - ra_valid is a one-cycle pulse per request. Back-to-back requests give consecutive valid cycles at full throughput; no stall or backpressure.
  - ra_req=0 at an edge -> ra_valid=0 and ra_data holds its previous value. It is not cleared.
- Write-first bypass: if we=1, waddr==ra_addr and a request is taken at the same edge, ra_data = wdata (the new value), not the stale entry.
  - Excluded when ZERO_REG=1 and the address is 0: the read still returns 0.
- Address 0 with ZERO_REG=1 always reads 0, whatever was written or bypassed.
- Both ports on the same address in the same cycle: both return the identical value, including the bypass case.
- Address range: full 2^ADDR_W range is valid; no out-of-range case. Addresses are used unsigned, without wrap logic.
- Unknown or X inputs on an idle port (req=0) must not change state.

Decomposition:
- Shared package holds DATA_W/ADDR_W defaults and the ZERO_REG constant so decode and writeback use matching widths.
- Storage array and write logic live in the top module.
- Natural sub-module: regfile_read_port, instanced twice (A, B).
  - Inputs: req, addr, the storage read value, and the we/waddr/wdata bypass bus.
  - Contains the bypass mux, zero-register override, data register and valid flop.
  - Synchronous clr.

Test Plan:
- Reset: write entries, then assert clr for 1 cycle with ra_req=rb_req=1 -> ra_valid=rb_valid=0 and data 0. Reading entries 1..31 afterwards returns 0.
- Basic write/read: write 0xDEADBEEF to reg 7. Next cycle ra_req=1, ra_addr=7 -> one cycle later ra_data=0xDEADBEEF, ra_valid=1. The cycle after, with no request, ra_valid=0 and data held.
- Bypass: same cycle we=1, waddr=12, wdata=0x12345678, ra_req=1, ra_addr=12, rb_req=1, rb_addr=12 -> both ports return 0x12345678 next cycle. Reg 12 then reads back the same.
- Zero register: write 0xFFFFFFFF to reg 0 with a simultaneous read of reg 0 -> ra_data=0. A later read of reg 0 -> 0.
- Independent ports: back-to-back requests for 4 cycles, A reading regs 1,2,3,4 and B reading 31,30,29,28 (preloaded with the value 0x100+index) -> 4 consecutive valid cycles on each port with matching data, in order.
- Reset mid-stream: clr asserted in the same cycle as we=1, waddr=5 and ra_req=1 -> no valid pulse, and reg 5 reads 0 afterwards.
